// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory around it.
interface mem_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
);
   localparam int BEAT_W = $clog2(BURST_LEN);

   logic                  I_Req;
   logic [ADDR_WIDTH-1:0] I_Addr;
   logic                  I_Grant;
   logic                  I_RValid;
   logic                  I_Done;

   logic                  D_Req;
   logic                  D_RW;
   logic [ADDR_WIDTH-1:0] D_Addr;
   logic [DATA_WIDTH-1:0] D_WData;
   logic [BEAT_W-1:0]     D_Beat;
   logic                  D_Grant;
   logic                  D_RValid;
   logic                  D_Done;

   logic [DATA_WIDTH-1:0] RData;

   logic                  Mem_Req;
   logic                  Mem_RW;
   logic [ADDR_WIDTH-1:0] Mem_Addr;
   logic [DATA_WIDTH-1:0] Mem_WData;
   logic [DATA_WIDTH-1:0] Mem_RData;
   logic                  Mem_Ready;

   modport slave (
      input  I_Req, I_Addr, D_Req, D_RW, D_Addr, D_WData, Mem_RData, Mem_Ready,
      output I_Grant, I_RValid, I_Done, D_Beat, D_Grant, D_RValid, D_Done, RData,
             Mem_Req, Mem_RW, Mem_Addr, Mem_WData
   );

   modport master (
      output I_Req, I_Addr, D_Req, D_RW, D_Addr, D_WData, Mem_RData, Mem_Ready,
      input  I_Grant, I_RValid, I_Done, D_Beat, D_Grant, D_RValid, D_Done, RData,
             Mem_Req, Mem_RW, Mem_Addr, Mem_WData
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-side line reads and
// D-side line reads/writes, running a fixed-length burst per grant.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input logic              CLK,
   input logic              RESET,
   mem_bus_arbiter_if.slave bus
);
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam int OFF_W  = BEAT_W + 2;
   localparam int TAG_W  = ADDR_WIDTH - OFF_W;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_q, last_d;
   owner_t            win;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              rw_q, rw_d;
   logic              i_grant_q, i_grant_d;
   logic              d_grant_q, d_grant_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_rw_q, mem_rw_d;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      beat_d  = beat_q;
      tag_d   = tag_q;
      rw_d    = rw_q;

      // A tie goes to the side not served last; a lone requester always wins.
      win = (last_q == OWN_I) ? OWN_D : OWN_I;
      if (bus.I_Req && !bus.D_Req) win = OWN_I;
      else if (!bus.I_Req && bus.D_Req) win = OWN_D;

      case (state_q)
         S_IDLE: begin
            if (bus.I_Req || bus.D_Req) begin
               state_d = S_BUSY;
               owner_d = win;
               last_d  = win;
               beat_d  = '0;
               rw_d    = (win == OWN_D) && bus.D_RW;
               tag_d   = (win == OWN_D) ? bus.D_Addr[ADDR_WIDTH-1:OFF_W]
                                        : bus.I_Addr[ADDR_WIDTH-1:OFF_W];
            end
         end
         S_BUSY: begin
            if (bus.Mem_Ready) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      i_grant_d = (state_d != S_IDLE) && (owner_d == OWN_I);
      d_grant_d = (state_d != S_IDLE) && (owner_d == OWN_D);
      i_done_d  = (state_d == S_DONE) && (owner_d == OWN_I);
      d_done_d  = (state_d == S_DONE) && (owner_d == OWN_D);
      mem_req_d = (state_d == S_BUSY);
      mem_rw_d  = (state_d == S_BUSY) && rw_d;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (RESET) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_I;
         last_q    <= OWN_I;
         beat_q    <= '0;
         tag_q     <= '0;
         rw_q      <= 1'b0;
         i_grant_q <= 1'b0;
         d_grant_q <= 1'b0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         mem_req_q <= 1'b0;
         mem_rw_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         beat_q    <= beat_d;
         tag_q     <= tag_d;
         rw_q      <= rw_d;
         i_grant_q <= i_grant_d;
         d_grant_q <= d_grant_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         mem_req_q <= mem_req_d;
         mem_rw_q  <= mem_rw_d;
      end
   end

   // Beat index sits directly under the word offset, so the line address never carries into the tag.
   assign bus.Mem_Addr  = mem_req_q ? {tag_q, beat_q, 2'b00} : {ADDR_WIDTH{1'b0}};
   assign bus.Mem_WData = mem_rw_q ? bus.D_WData : {DATA_WIDTH{1'b0}};
   assign bus.Mem_Req   = mem_req_q;
   assign bus.Mem_RW    = mem_rw_q;
   assign bus.RData     = bus.Mem_RData;
   assign bus.D_Beat    = beat_q;
   assign bus.I_Grant   = i_grant_q;
   assign bus.D_Grant   = d_grant_q;
   assign bus.I_Done    = i_done_q;
   assign bus.D_Done    = d_done_q;
   assign bus.I_RValid  = mem_req_q && !rw_q && (owner_q == OWN_I) && bus.Mem_Ready;
   assign bus.D_RValid  = mem_req_q && !rw_q && (owner_q == OWN_D) && bus.Mem_Ready;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of pending requests and burst expansion.
module tb_mem_bus_arbiter;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BURST_LEN  = 4;
   localparam logic [31:0] LINE_MASK = ~32'(BURST_LEN * 4 - 1);

   logic  CLK = 1'b0;
   logic  RESET;
   int    errors = 0;
   int    checks = 0;
   string phase  = "init";

   // Model: outstanding requests, their captured attributes, and who was served last.
   bit          i_pend, d_pend, d_rw_s, last_d;
   logic [31:0] i_addr_s, d_addr_s;

   // Scenario knobs.
   int ready_every = 1;   // 0 = random ready, n = ready on every n-th busy cycle
   bit scramble    = 0;   // owner's Addr/RW lines change mid-burst
   bit drop_owner  = 0;   // owner's Req falls after beat 1
   int late_mode   = 0;   // 0 none, 1 directed late request at beat 1, 2 random
   int abort_at    = -1;  // assert reset when this beat is on the bus

   mem_bus_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)) bus ();

   mem_bus_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=no finish required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".I_Grant"},   64'(bus.I_Grant),   64'd0);
      check({tag, ".D_Grant"},   64'(bus.D_Grant),   64'd0);
      check({tag, ".I_RValid"},  64'(bus.I_RValid),  64'd0);
      check({tag, ".D_RValid"},  64'(bus.D_RValid),  64'd0);
      check({tag, ".I_Done"},    64'(bus.I_Done),    64'd0);
      check({tag, ".D_Done"},    64'(bus.D_Done),    64'd0);
      check({tag, ".Mem_Req"},   64'(bus.Mem_Req),   64'd0);
      check({tag, ".Mem_RW"},    64'(bus.Mem_RW),    64'd0);
      check({tag, ".Mem_Addr"},  64'(bus.Mem_Addr),  64'd0);
      check({tag, ".Mem_WData"}, 64'(bus.Mem_WData), 64'd0);
      check({tag, ".D_Beat"},    64'(bus.D_Beat),    64'd0);
   endtask

   task automatic quiet_inputs();
      bus.I_Req     = 1'b0;
      bus.D_Req     = 1'b0;
      bus.D_RW      = 1'b0;
      bus.I_Addr    = '0;
      bus.D_Addr    = '0;
      bus.D_WData   = $urandom;
      bus.Mem_RData = $urandom;
      bus.Mem_Ready = 1'b1;
   endtask

   task automatic apply_reset();
      RESET  = 1'b1;
      quiet_inputs();
      i_pend = 0;
      d_pend = 0;
      last_d = 0;
      @(posedge CLK); #1;
      @(negedge CLK);
      check_zero("reset");
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   // One IDLE cycle: pending requests are presented, nothing may be granted yet.
   task automatic idle_cycle();
      bus.I_Req     = i_pend;
      bus.D_Req     = d_pend;
      bus.I_Addr    = i_pend ? i_addr_s : $urandom;
      bus.D_Addr    = d_pend ? d_addr_s : $urandom;
      bus.D_RW      = d_pend ? d_rw_s : 1'($urandom_range(0, 1));
      bus.Mem_Ready = 1'($urandom_range(0, 1));
      bus.Mem_RData = $urandom;
      bus.D_WData   = $urandom;
      @(negedge CLK);
      check("idle.I_Grant",   64'(bus.I_Grant),   64'd0);
      check("idle.D_Grant",   64'(bus.D_Grant),   64'd0);
      check("idle.Mem_Req",   64'(bus.Mem_Req),   64'd0);
      check("idle.Mem_RW",    64'(bus.Mem_RW),    64'd0);
      check("idle.I_RValid",  64'(bus.I_RValid),  64'd0);
      check("idle.D_RValid",  64'(bus.D_RValid),  64'd0);
      check("idle.I_Done",    64'(bus.I_Done),    64'd0);
      check("idle.D_Done",    64'(bus.D_Done),    64'd0);
      check("idle.Mem_WData", 64'(bus.Mem_WData), 64'd0);
      @(posedge CLK); #1;
   endtask

   // One whole burst following an IDLE cycle that had a request pending.
   task automatic burst();
      bit          win_d, rw, rdy;
      logic [31:0] base, rd, wd;
      int          beat = 0;
      int          cyc  = 0;

      win_d  = (i_pend && d_pend) ? !last_d : d_pend;
      base   = (win_d ? d_addr_s : i_addr_s) & LINE_MASK;
      rw     = win_d && d_rw_s;
      last_d = win_d;

      while (beat < BURST_LEN) begin
         rdy = (ready_every == 0) ? 1'($urandom_range(0, 1))
                                  : ((cyc % ready_every) == ready_every - 1);
         rd  = $urandom;
         wd  = $urandom;
         bus.Mem_Ready = rdy;
         bus.Mem_RData = rd;
         bus.D_WData   = wd;
         if (scramble) begin
            if (win_d) begin
               bus.D_Addr = $urandom;
               bus.D_RW   = 1'($urandom_range(0, 1));
            end else begin
               bus.I_Addr = $urandom;
            end
         end
         if (drop_owner && beat >= 2) begin
            if (win_d) bus.D_Req = 1'b0;
            else       bus.I_Req = 1'b0;
         end
         if (late_mode != 0 && beat == 1) begin
            if (win_d && !i_pend && (late_mode == 1 || $urandom_range(0, 1) == 1)) begin
               i_pend     = 1;
               i_addr_s   = (late_mode == 1) ? 32'h0000_5008 : $urandom;
               bus.I_Req  = 1'b1;
               bus.I_Addr = i_addr_s;
            end else if (!win_d && !d_pend && (late_mode == 1 || $urandom_range(0, 1) == 1)) begin
               d_pend     = 1;
               d_addr_s   = (late_mode == 1) ? 32'h0000_5008 : $urandom;
               d_rw_s     = (late_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
               bus.D_Req  = 1'b1;
               bus.D_Addr = d_addr_s;
               bus.D_RW   = d_rw_s;
            end
         end

         if (abort_at == beat) begin
            #2;
            RESET = 1'b1;
            #1;
            check_zero("abort_now");
            @(posedge CLK); #1;
            @(negedge CLK);
            check_zero("abort_held");
            @(posedge CLK); #1;
            RESET  = 1'b0;
            quiet_inputs();
            i_pend = 0;
            d_pend = 0;
            last_d = 0;
            return;
         end

         @(negedge CLK);
         check("busy.I_Grant",   64'(bus.I_Grant),   64'(!win_d));
         check("busy.D_Grant",   64'(bus.D_Grant),   64'(win_d));
         check("busy.Mem_Req",   64'(bus.Mem_Req),   64'd1);
         check("busy.Mem_RW",    64'(bus.Mem_RW),    64'(rw));
         check("busy.Mem_Addr",  64'(bus.Mem_Addr),  64'(base + 32'(beat * 4)));
         check("busy.D_Beat",    64'(bus.D_Beat),    64'(beat));
         check("busy.I_RValid",  64'(bus.I_RValid),  64'(!win_d && !rw && rdy));
         check("busy.D_RValid",  64'(bus.D_RValid),  64'(win_d && !rw && rdy));
         check("busy.I_Done",    64'(bus.I_Done),    64'd0);
         check("busy.D_Done",    64'(bus.D_Done),    64'd0);
         check("busy.Mem_WData", 64'(bus.Mem_WData), 64'(rw ? wd : 32'd0));
         check("busy.RData",     64'(bus.RData),     64'(rd));
         @(posedge CLK); #1;
         if (rdy) beat++;
         cyc++;
      end

      bus.Mem_Ready = 1'($urandom_range(0, 1));
      bus.D_WData   = $urandom;
      @(negedge CLK);
      check("done.I_Grant",   64'(bus.I_Grant),   64'(!win_d));
      check("done.D_Grant",   64'(bus.D_Grant),   64'(win_d));
      check("done.I_Done",    64'(bus.I_Done),    64'(!win_d));
      check("done.D_Done",    64'(bus.D_Done),    64'(win_d));
      check("done.Mem_Req",   64'(bus.Mem_Req),   64'd0);
      check("done.Mem_RW",    64'(bus.Mem_RW),    64'd0);
      check("done.I_RValid",  64'(bus.I_RValid),  64'd0);
      check("done.D_RValid",  64'(bus.D_RValid),  64'd0);
      check("done.Mem_WData", 64'(bus.Mem_WData), 64'd0);
      @(posedge CLK); #1;
      if (win_d) d_pend = 0;
      else       i_pend = 0;
   endtask

   task automatic serve();
      idle_cycle();
      if (i_pend || d_pend) burst();
   endtask

   initial begin
      RESET = 1'b1;
      quiet_inputs();

      phase = "reset";
      apply_reset();

      phase = "single_i";
      ready_every = 1;
      i_pend = 1; i_addr_s = 32'h0000_1004;
      serve();
      idle_cycle();

      phase = "tie";
      apply_reset();
      i_pend = 1; i_addr_s = 32'h0000_1100;
      d_pend = 1; d_addr_s = 32'h0000_2200; d_rw_s = 0;
      for (int k = 0; k < 4; k++) begin
         serve();
         i_pend = 1;
         d_pend = 1;
      end

      phase = "d_write_wait";
      apply_reset();
      ready_every = 3;
      d_pend = 1; d_addr_s = 32'h0000_2000; d_rw_s = 1;
      serve();
      ready_every = 1;

      phase = "req_drop";
      drop_owner = 1; scramble = 1;
      i_pend = 1; i_addr_s = 32'h0000_3010;
      serve();
      drop_owner = 0; scramble = 0;

      phase = "reset_mid_burst";
      abort_at = 2;
      i_pend = 1; i_addr_s = 32'h0000_6008;
      serve();
      abort_at = -1;
      phase = "tie_after_abort";
      i_pend = 1; i_addr_s = 32'h0000_7000;
      d_pend = 1; d_addr_s = 32'h0000_8004; d_rw_s = 0;
      serve();
      serve();

      phase = "late_arrival";
      late_mode = 1;
      i_pend = 1; i_addr_s = 32'h0000_4000;
      serve();
      late_mode = 0;
      serve();

      phase = "random";
      apply_reset();
      ready_every = 0; scramble = 1; late_mode = 2;
      for (int n = 0; n < 40; n++) begin
         drop_owner = 1'($urandom_range(0, 1));
         if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1; i_addr_s = $urandom;
         end
         if (!d_pend && $urandom_range(0, 1) == 1) begin
            d_pend = 1; d_addr_s = $urandom; d_rw_s = 1'($urandom_range(0, 1));
         end
         serve();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single main-memory port between the instruction-fetch refill path (I-side, read-only) and the data-cache refill/write-back path (D-side, read or write). It grants one requester at a time using round-robin arbitration and runs a fixed-length line burst against memory, advancing one word per `Mem_Ready`. It sits between the caches and main memory. Its `Done` pulses and per-beat valids let the cache controllers release the pipeline stalls raised by the hazard logic.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width; one beat carries one word; address step per beat is 4.
- `BURST_LEN`, 4, beats per line; power of two, at least 2.

Ports:
- `CLK` in 1: the single clock; rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `I_Req` in 1: I-side line-read request; held until `I_Done`.
- `I_Addr` in ADDR_WIDTH: I-side line address; low log2(BURST_LEN)+2 bits ignored.
- `I_Grant` out 1: I-side owns the bus.
- `I_RValid` out 1: `Mem_RData` is an I-side beat this cycle.
- `I_Done` out 1: one-cycle pulse when the I-side burst completes.
- `D_Req` in 1: D-side request; held until `D_Done`.
- `D_RW` in 1: D-side direction; 1 = write, 0 = read.
- `D_Addr` in ADDR_WIDTH: D-side line address; alignment handled as for `I_Addr`.
- `D_WData` in DATA_WIDTH: write word for beat `D_Beat`.
- `D_Beat` out log2(BURST_LEN): current beat index.
- `D_Grant` out 1: D-side owns the bus.
- `D_RValid` out 1: `Mem_RData` is a D-side read beat this cycle.
- `D_Done` out 1: one-cycle pulse when the D-side burst completes.
- `RData` out DATA_WIDTH: passthrough of `Mem_RData` to both sides.
- `Mem_Req` out 1: memory access active.
- `Mem_RW` out 1: 1 = write.
- `Mem_Addr` out ADDR_WIDTH: word address of the current beat.
- `Mem_WData` out DATA_WIDTH: equals `D_WData` while the D-side is writing, else 0.
- `Mem_RData` in DATA_WIDTH: memory read data.
- `Mem_Ready` in 1: the current beat completes this cycle (read data valid, or write accepted).

## Operation
- States:
  - IDLE: no grant, `Mem_Req`=0.
  - BUSY: burst in progress.
  - DONE: one cycle; the `Done` pulse of the owner is high.
- Transitions:
  - IDLE to BUSY when any `Req` is high.
  - BUSY to DONE on `Mem_Ready` with beat = BURST_LEN-1.
  - DONE to IDLE unconditionally.
- Arbitration happens in IDLE only. With a single requester, that requester wins. With both requesting, the side not served last wins.
  - The `last` register updates when a burst enters BUSY.
  - Reset value of `last` = I, so D wins the first tie.
- On grant, a request register latches the aligned base address (low bits forced to 0), the owner, and `RW` (always 0 for the I-side).
- `Req`, `Addr` and `RW` changes during BUSY or DONE are ignored. Dropping `Req` mid-burst does not abort; the burst completes.
- Beat counter: cleared on entering BUSY; increments on each `Mem_Ready` in BUSY. `Mem_Addr` = base + beat×4, computed modulo the line, so no carry into tag bits.
- `Grant` of the owner is high in BUSY and DONE.
- `RValid` of the owner = BUSY & ~RW & `Mem_Ready`; it is combinational, with `RData` = `Mem_RData`.
- `Mem_Req` = BUSY; `Mem_RW` = latched RW in BUSY, else 0.
- Reset values: state IDLE, beat 0, `last` = I, and every output 0.
- `RESET` asserted mid-burst aborts immediately. No `Done` pulse is generated; the requester re-issues after reset.

## Timing
- A request seen in IDLE at edge k puts the block in BUSY from cycle k+1, with `Grant` and `Mem_Req` high and beat 0 on the bus.
- Each beat takes at least 1 cycle and waits indefinitely for `Mem_Ready`.
- `Done` is high exactly one cycle, the cycle after the last `Mem_Ready`.
- Arbitration resumes in the IDLE cycle following DONE. With zero-wait memory, the minimum per-burst occupancy is 1 IDLE + BURST_LEN + 1 DONE cycles. Back-to-back bursts are therefore separated by 2 non-transfer cycles.
- A request arriving during BUSY or DONE waits, and is sampled in the next IDLE cycle.

## Test plan
- **Single I read:** `I_Req`=1, `I_Addr`=0x1004, `Mem_Ready` always 1.
  - `Mem_Addr` = 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles.
  - `I_RValid` is high 4 cycles; `I_Done` pulses once; `D_Grant` stays 0.
- **Tie after reset:** `I_Req` and `D_Req` (read) rise together.
  - D is served first; I is served after D's DONE+IDLE.
  - With both requests held continuously, grants alternate D, I, D, I.
- **D write with waits:** `D_RW`=1, `D_Addr`=0x2000, `Mem_Ready` high only every 3rd cycle.
  - `D_Beat` holds each value until `Mem_Ready`; `Mem_WData` tracks `D_WData`.
  - `Mem_RW`=1 throughout; `D_RValid` never asserts; `D_Done` pulses 1 cycle after the 4th ready.
- **Request drop:** `I_Req` deasserted after beat 1.
  - The burst still runs all 4 beats and `I_Done` pulses.
  - `I_Addr` changes mid-burst do not alter `Mem_Addr`.
- **Reset mid-burst:** `RESET` asserted asynchronously during beat 2.
  - All outputs go to 0 immediately; no `Done` pulse.
  - After release, a tie grants D first.
- **Late arrival:** `D_Req` raised during an I burst.
  - D is granted in the cycle after the I-side DONE/IDLE, with no lost request.
